// File: rtl/fifo_sr_write_arb_if.sv
// -----------------------------------------------------------------------------
// fifo_sr_write_arb_if
//
// Purpose : bundles the requester side and the FIFO write side of the
//           single-port FIFO write arbiter into one interface.
//
// Signals :
//   req         [FLUX]             per-requester request
//   req_data    [FLUX*DATA_WIDTH]  flattened payloads, slice i = [i*DW +: DW]
//   flow_en     [FLUX]             per-flow enable mask
//   gnt         [FLUX]             same-cycle acceptance, one-hot or zero
//   fifo_din    [DATA_WIDTH+IDW]   registered FIFO word {flow id, payload}
//   fifo_write  [1]                registered FIFO write strobe
//   fifo_full   [FLUX]             per-flow full flags from the FIFO
//   write_count [32]               total words written since reset
//
// Modports:
//   master : requesters plus FIFO model (drives req/data/enables/full)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface fifo_sr_write_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FLUX       = 4
);
    localparam int IDW = $clog2(FLUX);

    logic [FLUX-1:0]            req;
    logic [FLUX*DATA_WIDTH-1:0] req_data;
    logic [FLUX-1:0]            flow_en;
    logic [FLUX-1:0]            gnt;
    logic [DATA_WIDTH+IDW-1:0]  fifo_din;
    logic                       fifo_write;
    logic [FLUX-1:0]            fifo_full;
    logic [31:0]                write_count;

    modport master (
        output req,
        output req_data,
        output flow_en,
        output fifo_full,
        input  gnt,
        input  fifo_din,
        input  fifo_write,
        input  write_count
    );

    modport slave (
        input  req,
        input  req_data,
        input  flow_en,
        input  fifo_full,
        output gnt,
        output fifo_din,
        output fifo_write,
        output write_count
    );
endinterface : fifo_sr_write_arb_if

// File: rtl/fifo_sr_write_arb.sv
// -----------------------------------------------------------------------------
// fifo_sr_write_arb
//
// Purpose : round-robin arbiter that merges FLUX requesters onto the single
//           write port of a multi-flow FIFO. Each accepted payload is written
//           one cycle after its grant, tagged with its flow id in the top IDW
//           bits of the FIFO word. A flow whose previous word is still on the
//           write port is skipped, so one flow writes at most every other
//           cycle while several flows together keep the port busy every cycle.
//
// Ports   :
//   clk   input   single clock, rising edge
//   rst   input   synchronous reset, active low
//   bus   slave   fifo_sr_write_arb_if (requests, grants, FIFO write port,
//                 full flags, write counter)
// -----------------------------------------------------------------------------
module fifo_sr_write_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int FLUX       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_sr_write_arb_if.slave   bus
);
    localparam int IDW = $clog2(FLUX);

    typedef logic [IDW-1:0]            id_t;
    typedef logic [DATA_WIDTH-1:0]     payload_t;
    typedef logic [DATA_WIDTH+IDW-1:0] word_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    word_t       fifo_din_q,    fifo_din_d;
    logic        fifo_write_q,  fifo_write_d;
    id_t         ptr_q,         ptr_d;
    logic [31:0] write_count_q, write_count_d;

    // ---------------------------------------------------------------------
    // Arbitration signals
    // ---------------------------------------------------------------------
    logic [FLUX-1:0] inflight;
    logic [FLUX-1:0] eligible;
    logic [FLUX-1:0] gnt;
    logic            grant_vld;
    id_t             grant_id;
    payload_t        grant_payload;

    // A flow is in flight while its word sits on the write port: the FIFO's
    // full flag does not yet account for it, so granting the same flow again
    // this cycle could overrun a nearly-full queue.
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            inflight[i] = fifo_write_q && (fifo_din_q[DATA_WIDTH +: IDW] == id_t'(i));
        end
    end

    // Reset gates eligibility so no grant can be shown while rst is low.
    always_comb begin
        if (!rst) begin
            eligible = '0;
        end else begin
            eligible = bus.req & bus.flow_en & ~bus.fifo_full & ~inflight;
        end
    end

    // Round-robin search starting at ptr_q and wrapping modulo FLUX. The
    // explicit modulo keeps ids below FLUX when FLUX is not a power of two.
    // NOTE: every variable written in a combinational block gets a default
    // before any conditional assignment; otherwise a latch is inferred.
    always_comb begin
        id_t idx;
        idx       = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int off = 0; off < FLUX; off++) begin
            idx = id_t'((int'(ptr_q) + off) % FLUX);
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (grant_vld) begin
            gnt[grant_id] = 1'b1;
        end
    end

    assign grant_payload = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        ptr_d         = ptr_q;
        fifo_write_d  = 1'b0;
        fifo_din_d    = fifo_din_q;
        write_count_d = write_count_q;

        if (grant_vld) begin
            // Pointer moves just past the winner so it becomes lowest priority.
            ptr_d         = (int'(grant_id) == FLUX-1) ? id_t'(0) : grant_id + id_t'(1);
            fifo_write_d  = 1'b1;
            fifo_din_d    = {grant_id, grant_payload};
            // Counter advances together with the strobe, so it reads as the
            // number of words presented so far, including the current one.
            write_count_d = write_count_q + 32'd1;
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // A word registered before reset is dropped, never written.
            fifo_din_q    <= '0;
            fifo_write_q  <= 1'b0;
            ptr_q         <= '0;
            write_count_q <= '0;
        end else begin
            fifo_din_q    <= fifo_din_d;
            fifo_write_q  <= fifo_write_d;
            ptr_q         <= ptr_d;
            write_count_q <= write_count_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.gnt         = gnt;
    assign bus.fifo_din    = fifo_din_q;
    assign bus.fifo_write  = fifo_write_q;
    assign bus.write_count = write_count_q;

endmodule : fifo_sr_write_arb

// File: tb/tb_fifo_sr_write_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_sr_write_arb
//
// Directed stimulus with hand-computed grant vectors. Each expected grant
// pushes the word it should produce (id, payload, counter value) into a
// queue; an independent monitor pops and compares whenever fifo_write is
// high, and flags any write that nothing expected.
// -----------------------------------------------------------------------------
module tb_fifo_sr_write_arb;
    localparam int DW  = 32;
    localparam int FX  = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW+DW-1:0] din;
        logic [31:0]       count;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_sr_write_arb_if #(.DATA_WIDTH(DW), .FLUX(FX)) bus ();

    fifo_sr_write_arb #(.DATA_WIDTH(DW), .FLUX(FX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    logic [31:0] exp_count = '0;
    logic        mon_stop  = 1'b0;

    // Payload per flow, fixed for the whole run.
    localparam logic [DW-1:0] D0 = 32'h1111_0000;
    localparam logic [DW-1:0] D1 = 32'h2222_1111;
    localparam logic [DW-1:0] D2 = 32'hA5A5_A5A5;
    localparam logic [DW-1:0] D3 = 32'h4444_3333;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus: drive at the falling edge, check gnt
    // shortly after, and queue the word the expected grant must produce.
    task automatic cycle(input string name, input logic r, input logic [3:0] req,
                         input logic [3:0] en, input logic [3:0] full,
                         input logic [3:0] exp_gnt);
        logic [DW-1:0] data_v [FX];
        data_v = '{D0, D1, D2, D3};
        @(negedge clk);
        rst           = r;
        bus.req       = req;
        bus.flow_en   = en;
        bus.fifo_full = full;
        if (!r) begin
            exp_count = '0;
            exp_q.delete();
        end
        #1;
        check($sformatf("%s gnt", name), 64'(bus.gnt), 64'(exp_gnt));
        for (int i = 0; i < FX; i++) begin
            if (exp_gnt[i]) begin
                exp_count = exp_count + 32'd1;
                exp_q.push_back('{din: {IDW'(i), data_v[i]}, count: exp_count});
            end
        end
    endtask

    // Samples the state just after the reset edge.
    task automatic check_reset_state(input string name);
        @(posedge clk);
        #1;
        check($sformatf("%s fifo_write", name),  64'(bus.fifo_write),  64'd0);
        check($sformatf("%s fifo_din", name),    64'(bus.fifo_din),    64'd0);
        check($sformatf("%s write_count", name), 64'(bus.write_count), 64'd0);
    endtask

    task automatic do_reset(input string name);
        cycle(name, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        check_reset_state(name);
    endtask

    // Backdoor load of the write counter; only reaching the wrap point in
    // a short run needs it.
    task automatic preload(input logic [31:0] v);
        @(negedge clk);
        force dut.write_count_q = v;
        #1;
        release dut.write_count_q;
        exp_count = v;
        #1;
        check("preload write_count", 64'(bus.write_count), 64'(v));
    endtask

    // Monitor: compares each word presented on the write port.
    initial begin
        exp_t e;
        while (!mon_stop) begin
            @(posedge clk);
            #1;
            if (bus.fifo_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got din 0x%0h with nothing expected", bus.fifo_din);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_din",    64'(bus.fifo_din),    64'(e.din));
                    check("write_count", 64'(bus.write_count), 64'(e.count));
                end
            end
        end
    end

    initial begin
        bus.req       = '0;
        bus.flow_en   = '0;
        bus.fifo_full = '0;
        bus.req_data  = {D3, D2, D1, D0};

        // Reset holds grants low even with every flow requesting.
        cycle("rst_gnt", 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        check_reset_state("rst_state");

        // All flows requesting: strict rotation, one write per cycle.
        cycle("rr0", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0001);
        cycle("rr1", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0010);
        cycle("rr2", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0100);
        cycle("rr3", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1000);
        cycle("rr4", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0001);
        cycle("rr5", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0010);
        cycle("rr_idle", 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

        // Single flow: granted on alternate cycles only.
        do_reset("rst_single");
        cycle("single0", 1'b1, 4'b0100, 4'b1111, 4'b0000, 4'b0100);
        cycle("single1", 1'b1, 4'b0100, 4'b1111, 4'b0000, 4'b0000);
        cycle("single2", 1'b1, 4'b0100, 4'b1111, 4'b0000, 4'b0100);
        cycle("single3", 1'b1, 4'b0100, 4'b1111, 4'b0000, 4'b0000);
        cycle("single4", 1'b1, 4'b0100, 4'b1111, 4'b0000, 4'b0100);
        cycle("single_idle", 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

        // Flow 1 full: skipped; served soon after the flag clears.
        do_reset("rst_full");
        cycle("full0", 1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0001);
        cycle("full1", 1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0100);
        cycle("full2", 1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b1000);
        cycle("full3", 1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0001);
        cycle("full4", 1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0100);
        cycle("free0", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1000);
        cycle("free1", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0001);
        cycle("free2", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0010);
        cycle("full_idle", 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

        // Disabled flow never granted; enabling grants at once; disabling
        // after the grant leaves the registered write intact.
        do_reset("rst_en");
        cycle("dis0", 1'b1, 4'b0001, 4'b1110, 4'b0000, 4'b0000);
        cycle("dis1", 1'b1, 4'b0001, 4'b1110, 4'b0000, 4'b0000);
        cycle("dis2", 1'b1, 4'b0001, 4'b1110, 4'b0000, 4'b0000);
        cycle("en0",  1'b1, 4'b0001, 4'b1111, 4'b0000, 4'b0001);
        cycle("redis0", 1'b1, 4'b0001, 4'b1110, 4'b0000, 4'b0000);
        cycle("redis1", 1'b1, 4'b0001, 4'b1110, 4'b0000, 4'b0000);
        cycle("en_idle", 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

        // Mid-stream reset: pending word dropped, rotation restarts at 0.
        cycle("mid0", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0010);
        cycle("mid_rst", 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        check_reset_state("mid_state");
        cycle("mid1", 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0001);
        cycle("mid_idle", 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

        // Counter wrap: FFFFFFFF then 0 then 1.
        preload(32'hFFFF_FFFE);
        cycle("wrap0", 1'b1, 4'b0011, 4'b1111, 4'b0000, 4'b0010);
        cycle("wrap1", 1'b1, 4'b0011, 4'b1111, 4'b0000, 4'b0001);
        cycle("wrap2", 1'b1, 4'b0011, 4'b1111, 4'b0000, 4'b0010);
        cycle("wrap_idle", 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

        // Every queued word must have appeared within a few cycles.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("drain pending", 64'(exp_q.size()), 64'd0);

        mon_stop = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_sr_write_arb

// File: doc/fifo_sr_write_arb.md
FIFO_SR_WRITE_ARB -- requirements
Module: fifo_sr_write_arb

Interface
Parameters:
REQ-001 DATA_WIDTH, default 32, payload width per requester and per FIFO word.
REQ-002 FLUX, default 4, number of requesters and flows; SHALL be >= 2.
REQ-003 IDW, derived as $clog2(FLUX), not overridable; width of the flow-id tag.
Ports:
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req  input  FLUX  per-requester request; bit i means req_data slice i is valid.
REQ-007 req_data  input  FLUX*DATA_WIDTH  flattened payloads; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 flow_en  input  FLUX  per-flow enable mask; a disabled flow SHALL never be granted.
REQ-009 gnt  output  FLUX  same-cycle acceptance; at most one bit high per cycle.
REQ-010 fifo_din  output  DATA_WIDTH+IDW  registered FIFO word = {flow id, payload}; id in the top IDW bits.
REQ-011 fifo_write  output  1  registered write strobe to the FIFO write port.
REQ-012 fifo_full  input  FLUX  per-flow full flags from the FIFO, reflecting writes up to the previous edge.
REQ-013 write_count  output  32  total words written since reset.

Function
REQ-014 Flow i SHALL be eligible when req[i] & flow_en[i] & ~fifo_full[i] & ~inflight[i].
REQ-015 inflight[i] SHALL be fifo_write & (fifo_din id field == i); a flow SHALL NOT be granted while its previous write is still on the port.
REQ-016 Arbitration SHALL be round-robin: search eligible flows from ptr upward, modulo FLUX, and grant the first one found.
REQ-017 On a grant to flow k, ptr SHALL become (k+1) mod FLUX at the next edge; with no grant, ptr SHALL hold.
REQ-018 gnt SHALL be combinational from current inputs and state; gnt[k]=1 means req_data slice k is consumed at this edge.
REQ-019 Requesters SHALL hold req and req_data stable until granted; dropping req before grant is legal, and no word SHALL be written for it.
REQ-020 On a grant to k, the next edge SHALL load fifo_din={k[IDW-1:0], slice k} and fifo_write=1: grant-to-write latency of exactly 1 cycle.
REQ-021 With no grant, the next edge SHALL set fifo_write=0 and fifo_din SHALL hold its previous value.
REQ-022 A single flow SHALL write at most once per 2 cycles; with two or more eligible flows the port SHALL sustain 1 write per cycle.
REQ-023 fifo_full[i]=1 SHALL block flow i only; other flows SHALL proceed unaffected.
REQ-024 write_count SHALL increment by 1 on every cycle fifo_write=1 and SHALL wrap from 2^32-1 to 0.
REQ-025 Deasserting flow_en[i] while req[i]=1 SHALL block further grants to i and SHALL NOT cancel a write already registered.
REQ-026 FLUX not a power of two: id values >= FLUX SHALL never be produced.

Reset
REQ-027 While rst=0 at an edge: fifo_write=0, fifo_din=0, ptr=0, write_count=0.
REQ-028 gnt SHALL be all-zero whenever rst=0, regardless of req.
REQ-029 Reset asserted mid-stream SHALL discard the registered word; no write SHALL occur on the cycle after reset is applied.

Verification
REQ-030 Single flow: req=4'b0100 held, data 0xA5A5A5A5, FIFO not full -> gnt=4'b0100 on alternate cycles; fifo_din=0x2_A5A5A5A5 with fifo_write=1 one cycle after each grant; write_count +1 per write.
REQ-031 All four flows requesting continuously after reset -> grants 0,1,2,3,0,... one per cycle; fifo_write stays 1 from cycle 2 onward.
REQ-032 fifo_full=4'b0010 with req=4'b1111 -> flow 1 never granted; rotation 0,2,3,0,...; releasing full -> flow 1 served within FLUX cycles.
REQ-033 flow_en=4'b1110 with req=4'b0001 -> gnt=0 and fifo_write=0 indefinitely; setting flow_en[0]=1 -> grant on that cycle, write on the next.
REQ-034 rst=0 for one cycle while fifo_write=1 -> next cycle fifo_write=0, fifo_din=0, write_count=0, and arbitration restarts from flow 0.
REQ-035 Preload write_count near wrap (0xFFFFFFFF after back-to-back writes) -> next write shows 0x00000000.
